pipe_reg_chain: RTL



---
 rtl/pipe_reg_chain.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage register slice chain with ready/valid flow
// control and bubble collapse, for pipelining between datapath blocks.
//
// Parameters:
//   DATA_WIDTH  word width
//   DEPTH       number of register stages, legal range 1..16
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (clears valids and data)
//   flush      synchronous clear of all stage valids (data held)
//   in_valid   upstream word present
//   in_ready   chain accepts in_data this cycle
//   in_data    upstream word
//   out_valid  valid of the last stage
//   out_ready  downstream accepts this cycle
//   out_data   data of the last stage
//   occupancy  count of valid stages, registered
//              (present only when PIPE_REG_CHAIN_OCC_EN is defined)
//
// Optional feature macro: PIPE_REG_CHAIN_OCC_EN

module pipe_reg_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  generate
    if ((DEPTH < 1) || (DEPTH > 16)) begin : g_bad_depth
      $error("pipe_reg_chain: DEPTH must be in 1..16");
    end
  endgenerate

  logic [DEPTH-1:0]      r_v;
  logic [DATA_WIDTH-1:0] r_d [DEPTH];

  logic [DEPTH-1:0]      w_rdy;
  logic [DEPTH-1:0]      w_up_v;
  logic [DATA_WIDTH-1:0] w_up_d [DEPTH];
  logic [DEPTH-1:0]      w_v_nxt;
  logic                  w_acc;

  // A stage is ready when it, or any stage after it, is empty, or when the
  // output drains. Accumulating from the output end keeps the chain free of
  // a self-referencing vector.
  always_comb begin
    w_acc = out_ready;
    w_rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_acc    = w_acc | ~r_v[i];
      w_rdy[i] = w_acc;
    end
  end

  // Upstream view of each stage: the input port for stage 0,
  // the previous register otherwise.
  always_comb begin
    w_up_v[0] = in_valid;
    w_up_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_up_v[i] = r_v[i-1];
      w_up_d[i] = r_d[i-1];
    end
  end

  always_comb begin
    w_v_nxt = r_v;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rdy[i]) begin
        w_v_nxt[i] = w_up_v[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      r_v <= w_v_nxt;
      // Data only moves with a valid word, so idle stages never toggle.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i] && w_up_v[i]) begin
          r_d[i] <= w_up_d[i];
        end
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~flush & ~reset;
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;

  // Count the next-state valids so the count lands on the same edge as v.
  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  assign occupancy = r_occ;
`endif

endmodule
